// File: rtl/bmp565_fifo_unpack.sv
// Pops bytes from an 8-bit FIFO read port, skips a BMP RGB565 header (checking 'BM'),
// and packs the payload into a valid/ready RGB565 pixel stream with sof/eol/eof markers.
module bmp565_fifo_unpack #(
  parameter int WIDTH     = 16,
  parameter int HEIGHT    = 16,
  parameter int HDR_BYTES = 66
) (
  input  logic        I_rclk,
  input  logic        I_rrst,
  input  logic        I_rempty,
  input  logic [7:0]  I_rdata,
  output logic        O_rinc,
  output logic        O_pix_vld,
  input  logic        I_pix_rdy,
  output logic [15:0] O_pix_data,
  output logic        O_sof,
  output logic        O_eol,
  output logic        O_eof,
  output logic        O_hdr_err
);

  typedef enum logic {
    ST_HDR = 1'b0,
    ST_PIX = 1'b1
  } state_t;

  localparam logic [15:0] X_LAST   = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST   = 16'(HEIGHT - 1);
  localparam logic [15:0] HDR_LAST = 16'(HDR_BYTES - 1);

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  q_mem_r [4];
  logic [1:0]  wr_ptr_r;
  logic [1:0]  rd_ptr_r;
  logic [2:0]  q_cnt_r;
  logic        inflight_r;
  logic [15:0] hdr_cnt_r;
  logic [15:0] x_r;
  logic [15:0] y_r;
  logic        pix_vld_r;
  logic [15:0] pix_data_r;
  logic        sof_r;
  logic        eol_r;
  logic        eof_r;
  logic        hdr_err_r;

  logic [7:0]  head_s;
  logic [7:0]  second_s;
  logic [2:0]  q_sum_s;
  logic        rinc_s;
  logic        x_last_s;
  logic        eof_s;
  logic        hdr_drop_s;
  logic        pix_load_s;
  logic        bad_magic_s;
  logic [1:0]  deq_s;

  assign head_s   = q_mem_r[rd_ptr_r];
  assign second_s = q_mem_r[rd_ptr_r + 2'd1];
  // Reserving a slot for the byte still in flight is what keeps the 4-entry queue from overflowing.
  assign q_sum_s  = q_cnt_r + {2'b00, inflight_r};
  assign rinc_s   = !I_rrst && !I_rempty && (q_sum_s < 3'd4);
  assign x_last_s = (x_r == X_LAST);
  assign eof_s    = x_last_s && (y_r == Y_LAST);

  // Next-state and dequeue decisions for header skipping and pixel packing.
  always_comb begin
    state_s     = state_r;
    hdr_drop_s  = 1'b0;
    pix_load_s  = 1'b0;
    bad_magic_s = 1'b0;
    deq_s       = 2'd0;
    case (state_r)
      ST_HDR: begin
        if (q_cnt_r != 3'd0) begin
          hdr_drop_s = 1'b1;
          deq_s      = 2'd1;
          if (hdr_cnt_r == 16'd0) begin
            bad_magic_s = (head_s != 8'h42);
          end else if (hdr_cnt_r == 16'd1) begin
            bad_magic_s = (head_s != 8'h4D);
          end else begin
            bad_magic_s = 1'b0;
          end
          if (hdr_cnt_r == HDR_LAST) begin
            state_s = ST_PIX;
          end else begin
            state_s = ST_HDR;
          end
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_PIX: begin
        if ((q_cnt_r >= 3'd2) && (!pix_vld_r || I_pix_rdy)) begin
          pix_load_s = 1'b1;
          deq_s      = 2'd2;
          if (eof_s) begin
            state_s = ST_HDR;
          end else begin
            state_s = ST_PIX;
          end
        end else begin
          state_s = ST_PIX;
        end
      end
      default: begin
        state_s = ST_HDR;
      end
    endcase
  end

  // State register.
  always_ff @(posedge I_rclk) begin
    if (I_rrst) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_s;
    end
  end

  // Byte queue: the byte returned by last cycle's pop is always written, whatever downstream does.
  always_ff @(posedge I_rclk) begin
    if (I_rrst) begin
      inflight_r <= 1'b0;
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      q_cnt_r    <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        q_mem_r[i] <= 8'd0;
      end
    end else begin
      inflight_r <= rinc_s;
      if (inflight_r) begin
        q_mem_r[wr_ptr_r] <= I_rdata;
        wr_ptr_r          <= wr_ptr_r + 2'd1;
      end
      rd_ptr_r <= rd_ptr_r + deq_s;
      q_cnt_r  <= q_cnt_r + {2'b00, inflight_r} - {1'b0, deq_s};
    end
  end

  // Header byte counter and pixel position counters.
  always_ff @(posedge I_rclk) begin
    if (I_rrst) begin
      hdr_cnt_r <= 16'd0;
      x_r       <= 16'd0;
      y_r       <= 16'd0;
    end else begin
      if (hdr_drop_s) begin
        hdr_cnt_r <= hdr_cnt_r + 16'd1;
      end
      if (pix_load_s) begin
        if (eof_s) begin
          hdr_cnt_r <= 16'd0;
          x_r       <= 16'd0;
          y_r       <= 16'd0;
        end else if (x_last_s) begin
          x_r <= 16'd0;
          y_r <= y_r + 16'd1;
        end else begin
          x_r <= x_r + 16'd1;
        end
      end
    end
  end

  // Pixel output register with markers, plus the header error pulse.
  always_ff @(posedge I_rclk) begin
    if (I_rrst) begin
      pix_vld_r  <= 1'b0;
      pix_data_r <= 16'd0;
      sof_r      <= 1'b0;
      eol_r      <= 1'b0;
      eof_r      <= 1'b0;
      hdr_err_r  <= 1'b0;
    end else begin
      hdr_err_r <= bad_magic_s;
      if (pix_load_s) begin
        pix_vld_r  <= 1'b1;
        pix_data_r <= {second_s, head_s};
        sof_r      <= (x_r == 16'd0) && (y_r == 16'd0);
        eol_r      <= x_last_s;
        eof_r      <= eof_s;
      end else if (I_pix_rdy) begin
        pix_vld_r <= 1'b0;
      end
    end
  end

  assign O_rinc     = rinc_s;
  assign O_pix_vld  = pix_vld_r;
  assign O_pix_data = pix_data_r;
  assign O_sof      = sof_r;
  assign O_eol      = eol_r;
  assign O_eof      = eof_r;
  assign O_hdr_err  = hdr_err_r;

endmodule
